// File: rtl/io_port_bank_pkg.sv
// Shared constants and address-map helpers for the io_port_bank register block.
package io_port_bank_pkg;

    localparam int unsigned CTRL_IRQ_EN = 0;

    function automatic int unsigned addr_status(input int unsigned n_in, input int unsigned n_out);
        return n_in + n_out;
    endfunction

    function automatic int unsigned addr_ctrl(input int unsigned n_in, input int unsigned n_out);
        return n_in + n_out + 1;
    endfunction

endpackage

// File: rtl/io_port_bank_change.sv
// One input channel: registered sample plus sticky change flag, where a new change beats a clear.
module io_change_detect #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  changed
);

    logic set;

    assign set = (din != q);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Load the live value so the first post-reset cycle sees no change.
            q       <= din;
            changed <= 1'b0;
        end else begin
            q <= din;
            if (set)
                changed <= 1'b1;
            else if (clr)
                changed <= 1'b0;
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of registered input channels, strobed output registers,
// sticky change status and a level interrupt behind a one-cycle-latency bus.
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter int unsigned N_INPUTS   = 2,
    parameter int unsigned N_OUTPUTS  = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(N_INPUTS + N_OUTPUTS + 2)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_INPUTS*DATA_WIDTH-1:0]   inputs,
    output logic [N_OUTPUTS*DATA_WIDTH-1:0]  outputs,
    output logic [N_OUTPUTS-1:0]             out_strobe,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic [N_INPUTS-1:0]              changed,
    output logic                             irq
);

    localparam int unsigned A_STATUS = addr_status(N_INPUTS, N_OUTPUTS);
    localparam int unsigned A_CTRL   = addr_ctrl(N_INPUTS, N_OUTPUTS);

    logic [N_INPUTS*DATA_WIDTH-1:0] in_q;
    logic [N_INPUTS-1:0]            clr_vec;
    logic [N_OUTPUTS-1:0]           wr_hit;
    logic [DATA_WIDTH-1:0]          rd_mux;
    logic                           irq_en;
    int unsigned                    a_idx;

    assign a_idx = 32'(addr);

    genvar g;
    generate
        for (g = 0; g < N_INPUTS; g++) begin : g_in
            io_change_detect #(.DATA_WIDTH(DATA_WIDTH)) u_cd (
                .clk     (clk),
                .rst     (rst),
                .din     (inputs[g*DATA_WIDTH +: DATA_WIDTH]),
                .clr     (clr_vec[g]),
                .q       (in_q[g*DATA_WIDTH +: DATA_WIDTH]),
                .changed (changed[g])
            );
        end
    endgenerate

    // Clear sources: reading the channel itself, or writing 1 to its STATUS bit.
    always_comb begin
        clr_vec = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            clr_vec[i] = (rd_en && (a_idx == i)) ||
                         (wr_en && (a_idx == A_STATUS) && wr_data[i]);
        end
    end

    always_comb begin
        wr_hit = '0;
        for (int unsigned j = 0; j < N_OUTPUTS; j++) begin
            wr_hit[j] = wr_en && (a_idx == N_INPUTS + j);
        end
    end

    // Read mux sees pre-edge register state, so same-cycle read+write returns the old value.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (a_idx == i)
                rd_mux = in_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int unsigned j = 0; j < N_OUTPUTS; j++) begin
            if (a_idx == N_INPUTS + j)
                rd_mux = outputs[j*DATA_WIDTH +: DATA_WIDTH];
        end
        if (a_idx == A_STATUS)
            rd_mux[N_INPUTS-1:0] = changed;
        if (a_idx == A_CTRL)
            rd_mux[CTRL_IRQ_EN] = irq_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outputs    <= '0;
            out_strobe <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            out_strobe <= wr_hit;
            for (int unsigned j = 0; j < N_OUTPUTS; j++) begin
                if (wr_hit[j])
                    outputs[j*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
            end
            if (wr_en && (a_idx == A_CTRL))
                irq_en <= wr_data[CTRL_IRQ_EN];
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
        end
    end

    assign irq = irq_en & (|changed);

endmodule
